// File: rtl/div_int_gen.sv
// rtl/div_int_gen.sv - restoring integer divider, unsigned or optional signed (DIV_INT_GEN_SIGNED_EN)
module div_int_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             valid,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [WIDTH-1:0] x_mag, y_mag, q_fix, r_fix, rem_nxt;
  logic [WIDTH:0]   shifted;
  logic             sgn_eff, is_zero, is_ovf, fits;

`ifdef DIV_INT_GEN_SIGNED_EN
  logic q_neg, r_neg;
  assign sgn_eff = sgn;
  assign is_ovf  = sgn && (x == {1'b1, {(WIDTH-1){1'b0}}}) && (&y);
  assign q_fix   = q_neg ? -dvd : dvd;
  assign r_fix   = r_neg ? -rem : rem;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign sgn_eff    = 1'b0;
  assign is_ovf     = 1'b0;
  assign q_fix      = dvd;
  assign r_fix      = rem;
`endif

  assign is_zero = (y == '0);
  assign x_mag   = (sgn_eff && x[WIDTH-1]) ? -x : x;
  assign y_mag   = (sgn_eff && y[WIDTH-1]) ? -y : y;

  // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
  assign shifted = {rem, dvd[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvs});
  assign rem_nxt = fits ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (is_zero || is_ovf) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        valid     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      q   <= '0;
      r   <= '0;
      dbz <= 1'b0;
      ovf <= 1'b0;
`ifdef DIV_INT_GEN_SIGNED_EN
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          dvd <= x_mag;
          dvs <= y_mag;
          rem <= '0;
          dbz <= is_zero;
          ovf <= is_ovf && !is_zero;
          r   <= '0;
          // overflow case answers immediately with the dividend as quotient
          q   <= (is_ovf && !is_zero) ? x : '0;
`ifdef DIV_INT_GEN_SIGNED_EN
          q_neg <= sgn_eff & (x[WIDTH-1] ^ y[WIDTH-1]);
          r_neg <= sgn_eff & x[WIDTH-1];
`endif
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= {dvd[WIDTH-2:0], fits};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          q <= q_fix;
          r <= r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_int_gen.sv
// tb/tb_div_int_gen.sv - randomized self-checking bench for div_int_gen against an arithmetic model
module tb_div_int_gen;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, sgn;
  logic [W-1:0] x, y, q, r;
  logic         busy, valid, dbz, ovf;

  int tests = 0;
  int fails = 0;

  div_int_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn), .x(x), .y(y),
    .busy(busy), .valid(valid), .dbz(dbz), .ovf(ovf), .q(q), .r(r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic ed, output logic eo, output int lat);
    logic sg;
    int   sa, sb, sq, sr;
`ifdef DIV_INT_GEN_SIGNED_EN
    sg = s;
`else
    sg = 1'b0;
`endif
    ed = 1'b0; eo = 1'b0; eq = '0; er = '0; lat = W + 2;
    if (b == 0) begin
      ed = 1'b1; lat = 1;
    end else if (sg && a == (1 << (W-1)) && b == (1 << W) - 1) begin
      eo = 1'b1; eq = a; lat = 1;
    end else if (sg) begin
      sa = a; sb = b;
      if (a[W-1]) sa = sa - (1 << W);
      if (b[W-1]) sb = sb - (1 << W);
      sq = sa / sb;
      sr = sa % sb;
      eq = sq[W-1:0];
      er = sr[W-1:0];
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke_busy, input bit poke_done);
    logic [W-1:0] eq, er;
    logic         ed, eo;
    int           elat, got_lat;
    bit           saw_busy;
    model(s, a, b, eq, er, ed, eo, elat);
    sgn = s; x = a; y = b; start = 1'b1;
    @(posedge clk);
    got_lat = 0; saw_busy = 0;
    for (int k = 1; k <= W + 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_busy && k == 2) begin
        start = 1'b1; x = 4'd15; y = 4'd1;
      end
      if (busy) saw_busy = 1;
      if (k == 1 && elat > 1) begin
        check("clr_q", q, 0);
        check("clr_r", r, 0);
      end
      if (valid) begin
        got_lat = k;
        break;
      end
    end
    check("latency", got_lat, elat);
    check("q", q, eq);
    check("r", r, er);
    check("dbz", dbz, ed);
    check("ovf", ovf, eo);
    check("busy_seen", saw_busy, elat > 1);
    if (poke_done) begin
      start = 1'b1; x = 4'd15; y = 4'd1; sgn = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    check("pulse_end", valid, 0);
    if (poke_done) check("done_start_ign", busy, 0);
    @(negedge clk);
    check("hold_q", q, eq);
    check("hold_r", r, er);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    bit nv;
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", {busy, valid, dbz, ovf, q, r}, 0);
    rst_n = 1'b1;
    do_op(1'b0, 4'd13, 4'd4, 0, 0);
    do_op(1'b1, 4'b1001, 4'd2, 0, 0);
    do_op(1'b0, 4'd5, 4'd0, 0, 0);
    do_op(1'b1, 4'b1000, 4'b1111, 0, 0);
    do_op(1'b0, 4'd13, 4'd4, 1, 0);
    do_op(1'b0, 4'd7, 4'd2, 0, 1);

    sgn = 1'b0; x = 4'd13; y = 4'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop_rst", {busy, valid, dbz, ovf, q, r}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (valid) nv = 1;
    end
    check("abort_valid", nv, 0);
    do_op(1'b0, 4'd9, 4'd3, 0, 0);

    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      if (i % 10 == 3) begin a = 4'b1000; b = 4'b1111; end
      do_op(1'($urandom_range(0, 1)), a, b, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/div_int_gen.md
DIV_INT_GEN -- requirements
Module: div_int_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a division, sampled on the clk edge.
REQ-005 The block SHALL have port sgn, input, 1 bit, selecting the mode (1 = two's-complement signed, 0 = unsigned), sampled with start.
REQ-006 The block SHALL have port x, input, WIDTH bits, the dividend, sampled with start.
REQ-007 The block SHALL have port y, input, WIDTH bits, the divisor, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a calculation is in progress.
REQ-009 The block SHALL have port valid, output, 1 bit, a one-cycle pulse marking q and r as valid.
REQ-010 The block SHALL have port dbz, output, 1 bit, the divide-by-zero flag.
REQ-011 The block SHALL have port ovf, output, 1 bit, the signed-overflow flag.
REQ-012 The block SHALL have port q, output, WIDTH bits, the quotient.
REQ-013 The block SHALL have port r, output, WIDTH bits, the remainder.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CALC, FIX, DONE.
REQ-015 In IDLE, start=1 SHALL capture x, y and sgn, and SHALL go to CALC, except in the REQ-020 and REQ-021 cases.
REQ-016 On entry to CALC, the block SHALL take operand magnitudes when sgn=1 and SHALL record quotient sign = x[MSB]^y[MSB] and remainder sign = x[MSB].
REQ-017 CALC SHALL perform restoring division, one quotient bit per cycle, for exactly WIDTH cycles, and SHALL then go to FIX.
REQ-018 FIX SHALL negate the quotient and/or remainder per the recorded signs, giving truncation toward zero with the remainder sign equal to the dividend sign; in unsigned mode FIX SHALL pass values through unchanged. FIX then goes to DONE.
REQ-019 DONE SHALL drive valid=1 for exactly one cycle, update q and r, and return to IDLE; total latency from the start edge to valid is WIDTH+2 cycles.
REQ-020 If y==0, the block SHALL skip CALC and FIX, set dbz=1 with q=0 and r=0, and pulse valid on the next cycle (latency 1).
REQ-021 If sgn=1, x is the most negative value and y is all ones (-1), the block SHALL set ovf=1 with q=x and r=0, and pulse valid after latency 1.
REQ-022 busy SHALL be high from the cycle after an accepted start through FIX inclusive, and SHALL be low in IDLE and DONE.
REQ-023 start while busy=1 or in DONE SHALL be ignored with no effect on the in-flight operation.
REQ-024 start in the same cycle as valid=1 SHALL NOT be accepted; a new start is accepted only from IDLE.
REQ-025 q, r, dbz and ovf SHALL hold their values until the next DONE or reset, and SHALL clear at the next accepted start.

Reset
REQ-026 Assertion of rst_n=0 SHALL immediately force IDLE and clear busy, valid, dbz, ovf, q and r to 0, including mid-operation.
REQ-027 An aborted operation SHALL produce no valid pulse after reset is released.
REQ-028 The first start SHALL be accepted on the first clk edge after rst_n goes high.

Configuration
REQ-029 With macro DIV_INT_GEN_SIGNED_EN defined, the block SHALL provide signed mode per REQ-016, REQ-018 and REQ-021.
REQ-030 Without DIV_INT_GEN_SIGNED_EN, the block SHALL ignore sgn, always divide unsigned, tie ovf to 0, and compile out the FIX negation logic while keeping identical latency.

Verification
REQ-031 WIDTH=4, sgn=0, x=13, y=4 -> valid 6 cycles after start, q=3, r=1, dbz=0, ovf=0.
REQ-032 WIDTH=4, sgn=1, x=-7 (4'b1001), y=2 -> q=-3 (4'b1101), r=-1 (4'b1111); with the macro absent -> q=4, r=1.
REQ-033 WIDTH=4, x=5, y=0 -> valid on the next cycle, dbz=1, q=0, r=0, busy never high.
REQ-034 WIDTH=4, sgn=1, x=-8, y=-1 -> ovf=1, q=4'b1000, r=0 after 1 cycle.
REQ-035 Start 13/4, then reapply start with x=15, y=1 at cycle 2 -> ignored, results q=3, r=1.
REQ-036 Start 13/4, then assert rst_n=0 at cycle 3 -> all outputs 0 and no valid pulse; a new start of 9/3 after reset -> q=3, r=0.
